// File: rtl/ovf_sequencer.sv
// ovf_sequencer: command-driven controller for the overflow counter datapath.
// It loads a start value, enables counting and counts overflow pulses. In
// periodic mode it reloads the counter after every overflow. It stops after
// a programmed number of overflows or on abort. It drives a toggling
// indicator pin and a one-cycle completion pulse.
//
// Optional feature: define OVF_SEQ_WATCHDOG_EN to add a WD_W-bit watchdog.
// The watchdog ends a run that sees no overflow for too long and flags wd_err.
// Without the macro, wd_err is constant 0 and no watchdog logic is built.

module ovf_sequencer #(
    parameter int CNT_W = 24,
    parameter int REP_W = 8,
    parameter int WD_W  = 26
) (
    input  logic             CLOCK_50,
    input  logic             KEY0,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_start,
    input  logic [REP_W-1:0] cmd_reps,
    input  logic             cmd_periodic,
    input  logic             abort,
    input  logic             ovrflow,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_value,
    output logic             cnt_en,
    output logic             busy,
    output logic             done,
    output logic             pin_out,
    output logic [REP_W-1:0] reps_left,
    output logic             wd_err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_RELOAD = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [REP_W-1:0] REPS_ONE  = {{(REP_W-1){1'b0}}, 1'b1};
    localparam logic [REP_W-1:0] REPS_ZERO = '0;

    state_t           r_state;
    logic             r_mode;       // 1 = reload after each overflow
    logic             r_pin;
    logic [REP_W-1:0] r_reps;
    logic [CNT_W-1:0] r_value;

    logic w_accept;
    logic w_wd_expire;
    logic w_in_run;
    logic w_abortable;

    assign w_accept    = cmd_valid && (r_state == S_IDLE);
    assign w_in_run    = (r_state == S_RUN);
    assign w_abortable = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_RELOAD);

`ifdef OVF_SEQ_WATCHDOG_EN
    // Expiry is flagged on the cycle whose increment would make the counter
    // all-ones. A run with no overflow therefore lasts 2**WD_W - 1 RUN cycles.
    localparam logic [WD_W-1:0] WD_LAST = {{(WD_W-1){1'b1}}, 1'b0};

    logic [WD_W-1:0] r_wd;
    logic            r_wd_err;

    assign w_wd_expire = w_in_run && !ovrflow && !abort && (r_wd == WD_LAST);

    // Watchdog count: free-runs in RUN and is held at zero elsewhere. That
    // clears it on every entry to RUN. Each sampled overflow also clears it.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_wd <= '0;
        end else if (w_in_run && !ovrflow) begin
            r_wd <= r_wd + 1'b1;
        end else begin
            r_wd <= '0;
        end
    end

    // Sticky error flag: set on expiry and cleared when the next command is accepted.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_wd_err <= 1'b0;
        end else if (w_accept) begin
            r_wd_err <= 1'b0;
        end else if (w_wd_expire) begin
            r_wd_err <= 1'b1;
        end
    end

    assign wd_err = r_wd_err;
`else
    assign w_wd_expire = 1'b0;
    // Without the watchdog the error flag never asserts.
    assign wd_err      = 1'b0 & (WD_W > 0);
`endif

    // Sequencer FSM: state, latched command fields, indicator pin and repeat count.
    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_pin   <= 1'b0;
            r_reps  <= '0;
            r_value <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_value <= cmd_start;
                        r_reps  <= cmd_reps;
                        r_mode  <= cmd_periodic;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= abort ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    if (abort) begin
                        // Abort wins over a coincident overflow: nothing is counted.
                        r_state <= S_DONE;
                    end else if (ovrflow) begin
                        r_pin <= ~r_pin;
                        if (r_reps == REPS_ONE) begin
                            r_reps  <= REPS_ZERO;
                            r_state <= S_DONE;
                        end else begin
                            // A zero count means unbounded, so it stays at zero.
                            if (r_reps != REPS_ZERO) begin
                                r_reps <= r_reps - 1'b1;
                            end
                            r_state <= r_mode ? S_RELOAD : S_RUN;
                        end
                    end else if (w_wd_expire) begin
                        r_state <= S_DONE;
                    end
                end
                S_RELOAD: begin
                    r_state <= abort ? S_DONE : S_RUN;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Moore decode of the control strobes from the state register alone.
    assign cmd_ready = (r_state == S_IDLE);
    assign cnt_load  = (r_state == S_LOAD) || (r_state == S_RELOAD);
    assign cnt_en    = w_in_run;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

    assign cnt_value = r_value;
    assign pin_out   = r_pin;
    assign reps_left = r_reps;

    // The abort decode documents which states respond to abort. Only the FSM
    // case arms act on it, so it is folded into an always-true expression here.
    logic w_unused;
    assign w_unused = w_abortable | ~w_abortable;

endmodule

// File: tb/tb_ovf_sequencer.sv
// Directed testbench for ovf_sequencer.
// A vector table covers the single-cycle behaviour. Hand-written sequences
// cover reset, long gaps, asynchronous reset, back-to-back commands and the
// watchdog.
`timescale 1ns/1ps

module tb_ovf_sequencer;

    localparam int CNT_W = 24;
    localparam int REP_W = 8;
    localparam int WD_W  = 4;

    localparam int ST_I  = 0;
    localparam int ST_L  = 1;
    localparam int ST_R  = 2;
    localparam int ST_RL = 3;
    localparam int ST_D  = 4;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [CNT_W-1:0] cmd_start;
    logic [REP_W-1:0] cmd_reps;
    logic             cmd_periodic;
    logic             abort;
    logic             ovrflow;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_en;
    logic             busy;
    logic             done;
    logic             pin_out;
    logic [REP_W-1:0] reps_left;
    logic             wd_err;

    int checks   = 0;
    int failures = 0;

    ovf_sequencer #(.CNT_W(CNT_W), .REP_W(REP_W), .WD_W(WD_W)) dut (
        .CLOCK_50     (clk),
        .KEY0         (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_start    (cmd_start),
        .cmd_reps     (cmd_reps),
        .cmd_periodic (cmd_periodic),
        .abort        (abort),
        .ovrflow      (ovrflow),
        .cnt_load     (cnt_load),
        .cnt_value    (cnt_value),
        .cnt_en       (cnt_en),
        .busy         (busy),
        .done         (done),
        .pin_out      (pin_out),
        .reps_left    (reps_left),
        .wd_err       (wd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             v;
        logic [CNT_W-1:0] st;
        logic [REP_W-1:0] rp;
        logic             per;
        logic             ab;
        logic             ov;
        int               e_st;
        logic             e_pin;
        logic [REP_W-1:0] e_reps;
        logic [CNT_W-1:0] e_val;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid    = 1'b0;
        cmd_start    = '0;
        cmd_reps     = '0;
        cmd_periodic = 1'b0;
        abort        = 1'b0;
        ovrflow      = 1'b0;
    endtask

    task automatic add(input logic v, input logic [CNT_W-1:0] st, input logic [REP_W-1:0] rp,
                       input logic per, input logic ab, input logic ov, input int e_st,
                       input logic e_pin, input logic [REP_W-1:0] e_reps, input logic [CNT_W-1:0] e_val);
        vec_t t;
        t.v = v; t.st = st; t.rp = rp; t.per = per; t.ab = ab; t.ov = ov;
        t.e_st = e_st; t.e_pin = e_pin; t.e_reps = e_reps; t.e_val = e_val;
        vq.push_back(t);
    endtask

    // Expected strobes follow from the state alone.
    task automatic chk_state(input string tag, input int st);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 32'(st == ST_I));
        chk({tag, ".cnt_load"},  32'(cnt_load),  32'((st == ST_L) || (st == ST_RL)));
        chk({tag, ".cnt_en"},    32'(cnt_en),    32'(st == ST_R));
        chk({tag, ".busy"},      32'(busy),      32'(st != ST_I));
        chk({tag, ".done"},      32'(done),      32'(st == ST_D));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int loads;
        int runs;
        int exp_pin;
        string tag;

        idle_inputs();
        rst_n = 1'b0;

        // Reset state.
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk_state("reset", ST_I);
        chk("reset.pin_out",   32'(pin_out),   32'd0);
        chk("reset.reps_left", 32'(reps_left), 32'd0);
        chk("reset.cnt_value", 32'(cnt_value), 32'd0);
        chk("reset.wd_err",    32'(wd_err),    32'd0);
        $display("reset: ready=%0d busy=%0d en=%0d pin=%0d reps=%0d", cmd_ready, busy, cnt_en, pin_out, reps_left);

        // Vector table: inputs applied before an edge, outputs expected after it.
        // One-shot, 3 reps. A command offered mid-run or in DONE is not taken.
        add(1, 24'h10,     3, 0, 0, 0, ST_L,  0, 3, 24'h10);
        add(0, 0,          0, 0, 0, 0, ST_R,  0, 3, 24'h10);
        add(0, 0,          0, 0, 0, 1, ST_R,  1, 2, 24'h10);
        add(1, 24'h123456, 7, 1, 0, 0, ST_R,  1, 2, 24'h10);
        add(0, 0,          0, 0, 0, 1, ST_R,  0, 1, 24'h10);
        add(0, 0,          0, 0, 0, 1, ST_D,  1, 0, 24'h10);
        add(1, 24'h777,    9, 0, 0, 0, ST_I,  1, 0, 24'h10);
        // Periodic, 2 reps. ovrflow in LOAD/RELOAD/DONE/IDLE and abort in IDLE are ignored.
        add(1, 24'h0ABCDE, 2, 1, 0, 0, ST_L,  1, 2, 24'h0ABCDE);
        add(0, 0,          0, 0, 0, 1, ST_R,  1, 2, 24'h0ABCDE);
        add(0, 0,          0, 0, 0, 1, ST_RL, 0, 1, 24'h0ABCDE);
        add(0, 0,          0, 0, 0, 1, ST_R,  0, 1, 24'h0ABCDE);
        add(0, 0,          0, 0, 0, 1, ST_D,  1, 0, 24'h0ABCDE);
        add(0, 0,          0, 0, 0, 1, ST_I,  1, 0, 24'h0ABCDE);
        add(0, 0,          0, 0, 0, 1, ST_I,  1, 0, 24'h0ABCDE);
        add(0, 0,          0, 0, 1, 0, ST_I,  1, 0, 24'h0ABCDE);
        // Unbounded run: five overflows, then abort coincident with a sixth.
        add(1, 24'hFFFFFF, 0, 0, 0, 0, ST_L,  1, 0, 24'hFFFFFF);
        add(0, 0,          0, 0, 0, 0, ST_R,  1, 0, 24'hFFFFFF);
        add(0, 0,          0, 0, 0, 1, ST_R,  0, 0, 24'hFFFFFF);
        add(0, 0,          0, 0, 0, 1, ST_R,  1, 0, 24'hFFFFFF);
        add(0, 0,          0, 0, 0, 1, ST_R,  0, 0, 24'hFFFFFF);
        add(0, 0,          0, 0, 0, 1, ST_R,  1, 0, 24'hFFFFFF);
        add(0, 0,          0, 0, 0, 1, ST_R,  0, 0, 24'hFFFFFF);
        add(0, 0,          0, 0, 1, 1, ST_D,  0, 0, 24'hFFFFFF);
        add(0, 0,          0, 0, 0, 0, ST_I,  0, 0, 24'hFFFFFF);
        // Abort in LOAD freezes reps_left.
        add(1, 24'h1,      5, 1, 0, 0, ST_L,  0, 5, 24'h1);
        add(0, 0,          0, 0, 1, 0, ST_D,  0, 5, 24'h1);
        add(0, 0,          0, 0, 0, 0, ST_I,  0, 5, 24'h1);
        // Abort in RELOAD.
        add(1, 24'h2,      4, 1, 0, 0, ST_L,  0, 4, 24'h2);
        add(0, 0,          0, 0, 0, 0, ST_R,  0, 4, 24'h2);
        add(0, 0,          0, 0, 0, 1, ST_RL, 1, 3, 24'h2);
        add(0, 0,          0, 0, 1, 0, ST_D,  1, 3, 24'h2);
        add(0, 0,          0, 0, 0, 0, ST_I,  1, 3, 24'h2);

        for (int i = 0; i < vq.size(); i++) begin
            cmd_valid    = vq[i].v;
            cmd_start    = vq[i].st;
            cmd_reps     = vq[i].rp;
            cmd_periodic = vq[i].per;
            abort        = vq[i].ab;
            ovrflow      = vq[i].ov;
            tick();
            tag = $sformatf("vec%0d", i);
            chk_state(tag, vq[i].e_st);
            chk({tag, ".pin_out"},   32'(pin_out),   32'(vq[i].e_pin));
            chk({tag, ".reps_left"}, 32'(reps_left), 32'(vq[i].e_reps));
            chk({tag, ".cnt_value"}, 32'(cnt_value), 32'(vq[i].e_val));
            $display("vec%0d: v=%0d ab=%0d ov=%0d -> ready=%0d load=%0d en=%0d done=%0d pin=%0d reps=%0d val=%0h",
                     i, vq[i].v, vq[i].ab, vq[i].ov, cmd_ready, cnt_load, cnt_en, done, pin_out, reps_left, cnt_value);
        end
        idle_inputs();

        // One-shot with overflows 20 cycles apart, starting from a cleared pin.
        do_reset();
        cmd_valid = 1'b1; cmd_start = 24'h000010; cmd_reps = 3; cmd_periodic = 1'b0;
        tick();
        idle_inputs();
        loads = cnt_load ? 1 : 0;
        exp_pin = 0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 20; j++) begin
                ovrflow = (j == 19);
                tick();
                ovrflow = 1'b0;
                if (cnt_load) loads++;
                if (!(p == 2 && j == 19)) begin
                    chk($sformatf("oneshot.en p%0d j%0d", p, j), 32'(cnt_en), 32'd1);
                end
            end
            exp_pin = exp_pin ^ 1;
            chk($sformatf("oneshot.pin p%0d", p), 32'(pin_out), 32'(exp_pin));
        end
        chk("oneshot.done_after_last", 32'(done), 32'd1);
        tick();
        chk("oneshot.done_one_cycle", 32'(done), 32'd0);
        chk("oneshot.ready_again", 32'(cmd_ready), 32'd1);
        chk("oneshot.load_pulses", 32'(loads), 32'd1);
        $display("oneshot: loads=%0d pin=%0d reps=%0d", loads, pin_out, reps_left);

        // Asynchronous reset between edges during RUN.
        cmd_valid = 1'b1; cmd_start = 24'h55; cmd_reps = 4; cmd_periodic = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk("areset.running", 32'(cnt_en), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("areset.now", ST_I);
        chk("areset.reps", 32'(reps_left), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("areset.no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        tick();
        chk_state("areset.after", ST_I);
        $display("areset: ready=%0d en=%0d done=%0d", cmd_ready, cnt_en, done);

        // Back-to-back commands at the minimum 4-cycle spacing.
        cmd_valid = 1'b1; cmd_start = 24'hA; cmd_reps = 1; cmd_periodic = 1'b0;
        tick();
        idle_inputs();
        chk_state("b2b.c1", ST_L);
        tick();
        chk_state("b2b.c2", ST_R);
        ovrflow = 1'b1;
        tick();
        ovrflow = 1'b0;
        chk_state("b2b.c3", ST_D);
        chk("b2b.pin", 32'(pin_out), 32'd1);
        chk("b2b.reps", 32'(reps_left), 32'd0);
        tick();
        chk_state("b2b.c4", ST_I);
        cmd_valid = 1'b1; cmd_start = 24'hB; cmd_reps = 6;
        tick();
        idle_inputs();
        chk_state("b2b.c5", ST_L);
        chk("b2b.val", 32'(cnt_value), 32'hB);
        chk("b2b.reps2", 32'(reps_left), 32'd6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        $display("b2b: second command accepted, ready=%0d", cmd_ready);

`ifdef OVF_SEQ_WATCHDOG_EN
        // Watchdog: a run with no overflow ends after 15 RUN cycles.
        cmd_valid = 1'b1; cmd_start = 24'h3; cmd_reps = 0; cmd_periodic = 1'b0;
        tick();
        idle_inputs();
        runs = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            if (cnt_en) runs++;
        end
        chk("wd.done", 32'(done), 32'd1);
        chk("wd.run_cycles", 32'(runs), 32'd15);
        chk("wd.err", 32'(wd_err), 32'd1);
        tick();
        chk("wd.err_sticky", 32'(wd_err), 32'd1);
        cmd_valid = 1'b1;
        tick();
        idle_inputs();
        chk("wd.err_cleared", 32'(wd_err), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        $display("wd: run_cycles=%0d", runs);
`else
        runs = 0;
        chk("wd.tied_off", 32'(wd_err), 32'(runs));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
